seven_seg_scan_controller: RTL
==============================

// Module: seven_seg_scan_controller
//
// PURPOSE
//   Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS
//   common-cathode digits. Holds a frame-coherent display value, feeds one
//   nibble per slot to the decoder, and drives a one-hot digit select.
//   Inserts a blanking interval at the start of each slot to suppress ghosting.
//   Supports optional leading-zero blanking. Sits between the host value
//   register and the board's segment/digit pins.
//
// PARAMETERS
//   NUM_DIGITS    4     digits scanned per frame (>=1)
//   PRESCALE      1000  clk cycles per digit slot (>=2)
//   BLANK_CYCLES  16    cycles at start of each slot with all outputs off
//                       (1 <= BLANK_CYCLES < PRESCALE)
//
// PORTS
//   clk        in   1              system clock, rising edge
//   rst_n      in   1              asynchronous reset, active low
//   enable     in   1              1 = scan, 0 = display dark
//   value      in   4*NUM_DIGITS   digit i = value[4*i+3:4*i]; digit 0 = LS
//   load       in   1              1-cycle request to capture value
//   lz_blank   in   1              1 = blank leading zero digits
//   hex_out    out  4              nibble to shared decoder input
//   seg_in     in   7              decoder output (combinational from hex_out)
//   seg_out    out  7              registered segment drive, active high
//   digit_sel  out  NUM_DIGITS     registered one-hot digit enable, active high
//   frame_done out  1              1-cycle pulse at end of each full frame
//   load_ack   out  1              1-cycle pulse when captured value applied
//
// BEHAVIOUR
//   - Reset: seg_out=0, digit_sel=0, hex_out=0, frame_done=0, load_ack=0;
//     display and pending registers=0; no load pending; state IDLE, idx=0, cnt=0.
//   - Registers: pending (captured by load), disp (value being scanned).
//   - FSM: IDLE -> BLANK -> SHOW -> BLANK (next idx) ... ; any state -> IDLE
//     on enable=0 (next cycle: digit_sel=0, seg_out=0, idx=0, cnt=0).
//   - IDLE with enable=1: go to BLANK, idx=0, cnt=0.
//   - Slot: cnt runs 0..PRESCALE-1. BLANK for cnt<BLANK_CYCLES, SHOW otherwise.
//     At cnt=PRESCALE-1 cnt wraps to 0 and idx increments, wrapping
//     NUM_DIGITS-1 -> 0.
//   - hex_out = disp nibble[idx] in every state (0 in IDLE); seg_in is
//     sampled only in SHOW.
//   - Outputs registered, one cycle behind state:
//     SHOW -> digit_sel=1<<idx, seg_out=seg_in; BLANK/IDLE -> both 0.
//     Each digit is lit for exactly PRESCALE-BLANK_CYCLES consecutive cycles
//     per frame.
//   - Leading-zero blank: if lz_blank=1, digit i>0 with disp nibble i..top all
//     zero is dark for its slot (digit_sel=0, seg_out=0). Digit 0 is never
//     blanked. lz_blank is sampled live.
//   - Load: load=1 copies value into pending and sets the pending flag. A
//     later load before apply overwrites pending; the latest value wins.
//   - Apply: at the frame boundary (idx=NUM_DIGITS-1, cnt=PRESCALE-1), or on
//     any cycle in IDLE, a set pending flag moves pending into disp, clears
//     the flag and pulses load_ack on the next cycle.
//   - load coincident with the boundary or IDLE cycle: that cycle's value is
//     applied directly and load_ack pulses. disp never changes mid-frame.
//   - frame_done pulses the cycle after each frame boundary, whether or not
//     a load is applied. It does not pulse in IDLE.
//   - Reset mid-frame: all outputs 0 immediately (async); pending is lost.
//
// TESTING  (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
//   1 Reset, enable=0, load value=16'h1234 -> load_ack next cycle,
//     outputs stay 0.
//   2 enable=1 -> per 8-cycle slot: 2 cycles dark, then 6 cycles lit;
//     digit_sel 0001,0010,0100,1000 with hex 4,3,2,1;
//     frame_done every 32 cycles.
//   3 Mid-frame load 16'hABCD -> disp unchanged until the boundary;
//     load_ack and frame_done in the same cycle; next frame shows D,C,B,A.
//   4 Two loads in one frame (16'h1111 then 16'h2222) -> a single load_ack;
//     next frame shows 2222.
//   5 lz_blank=1, value=16'h0050 -> digits 3 and 2 dark; digits 1 and 0 lit
//     (5, 0). value=16'h0000 -> only digit 0 lit, showing 0.
//   6 enable=0 mid-slot on digit 2 -> next cycle all outputs 0; enable=1
//     restarts at digit 0. rst_n low mid-SHOW -> outputs 0 in same cycle.

Source files
------------

// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller: multiplexed 7-segment scan with blanking, leading-zero suppression and frame-coherent loads
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    load_i,
    input  logic                    lz_blank_i,
    output logic [3:0]              hex_out_o,
    input  logic [6:0]              seg_in_i,
    output logic [6:0]              seg_out_o,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic                    frame_done_o,
    output logic                    load_ack_o
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(PRESCALE);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic                    pflag_q, pflag_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    fd_q, ack_q, ack_d;
    logic                    slot_end, last_digit, boundary, apply_win, lz_dark, lit;

    assign slot_end   = cnt_q == CW'(PRESCALE - 1);
    assign last_digit = idx_q == IW'(NUM_DIGITS - 1);
    assign boundary   = state_q != IDLE && last_digit && slot_end;
    assign apply_win  = state_q == IDLE || boundary;
    assign hex_out_o  = state_q == IDLE ? 4'h0 : disp_q[{idx_q, 2'b00} +: 4];
    assign lz_dark    = lz_blank_i && idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == '0;
    assign lit        = enable_i && state_q == SHOW && !lz_dark;
    assign seg_d      = lit ? seg_in_i : 7'h00;
    assign sel_d      = lit ? NUM_DIGITS'(1) << idx_q : '0;

    assign seg_out_o    = seg_q;
    assign digit_sel_o  = sel_q;
    assign frame_done_o = fd_q;
    assign load_ack_o   = ack_q;

    // Scan sequencing: slot counter, digit index and blank/show phase
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = BLANK;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
            idx_d   = slot_end ? (last_digit ? '0 : idx_q + 1'b1) : idx_q;
            state_d = cnt_d < CW'(BLANK_CYCLES) ? BLANK : SHOW;
        end
    end

    // Loads park in pending and only reach disp at a frame boundary or while idle
    always_comb begin
        disp_d  = disp_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        ack_d   = 1'b0;
        if (apply_win && (load_i || pflag_q)) begin
            disp_d  = load_i ? value_i : pend_q;
            pflag_d = 1'b0;
            ack_d   = 1'b1;
        end else if (load_i) begin
            pend_d  = value_i;
            pflag_d = 1'b1;
        end
    end

    // State, display registers and registered pin drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            pflag_q <= 1'b0;
            seg_q   <= '0;
            sel_q   <= '0;
            fd_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            fd_q    <= boundary;
            ack_q   <= ack_d;
        end
    end
endmodule
